// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder/fetch-side bundle for the program-counter sequencer
interface pc_sequencer_if #(
  parameter int CNTR_WIDTH  = 8,
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
);
  logic                  start;
  logic                  stall;
  logic                  op_valid;
  logic [2:0]            op_code;
  logic [CNTR_WIDTH-1:0] target;
  logic [CNTR_WIDTH-1:0] pc;
  logic                  pc_valid;
  logic                  redirect;
  logic [DEPTH_W-1:0]    depth;
  logic                  halted;
  logic [1:0]            fault;

  modport master (
    output start, stall, op_valid, op_code, target,
    input  pc, pc_valid, redirect, depth, halted, fault
  );

  modport slave (
    input  start, stall, op_valid, op_code, target,
    output pc, pc_valid, redirect, depth, halted, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - RUN/HALT/FAULT program-counter sequencer with return-address stack
module pc_sequencer #(
  parameter int CNTR_WIDTH  = 8,
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  pc_sequencer_if.slave     bus
);
  localparam int PTR_W = $clog2(STACK_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_HALT = 3'd4;

  localparam logic [1:0] FLT_NONE  = 2'b00;
  localparam logic [1:0] FLT_OVER  = 2'b01;
  localparam logic [1:0] FLT_UNDER = 2'b10;

  localparam logic [DEPTH_W-1:0]    DEPTH_FULL = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0]    DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [CNTR_WIDTH-1:0] PC_ONE     = CNTR_WIDTH'(1);

  logic [1:0]            state;
  logic [CNTR_WIDTH-1:0] pc;
  logic                  redirect;
  logic [DEPTH_W-1:0]    depth;
  logic [1:0]            fault;
  logic [CNTR_WIDTH-1:0] stack [STACK_DEPTH];

  logic                  run_go;
  logic [2:0]            op_eff;
  logic                  push;
  logic [CNTR_WIDTH-1:0] pc_inc;
  logic [PTR_W-1:0]      push_idx;
  logic [PTR_W-1:0]      top_idx;

  // An unstalled RUN cycle without a valid op behaves exactly like NOP.
  assign run_go   = (state == ST_RUN) && !bus.stall;
  assign op_eff   = bus.op_valid ? bus.op_code : 3'd0;
  assign push     = run_go && (op_eff == OP_CALL) && (depth != DEPTH_FULL);
  assign pc_inc   = pc + PC_ONE;
  assign push_idx = PTR_W'(depth);
  assign top_idx  = PTR_W'(depth - DEPTH_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= '0;
      redirect <= 1'b0;
      depth    <= '0;
      fault    <= FLT_NONE;
    end else begin
      redirect <= 1'b0;
      if (state == ST_RUN) begin
        if (!bus.stall) begin
          case (op_eff)
            OP_JMP: begin
              pc       <= bus.target;
              redirect <= 1'b1;
            end
            OP_CALL: begin
              if (depth == DEPTH_FULL) begin
                state <= ST_FAULT;
                fault <= FLT_OVER;
              end else begin
                pc       <= bus.target;
                depth    <= depth + DEPTH_ONE;
                redirect <= 1'b1;
              end
            end
            OP_RET: begin
              if (depth == '0) begin
                state <= ST_FAULT;
                fault <= FLT_UNDER;
              end else begin
                pc       <= stack[top_idx];
                depth    <= depth - DEPTH_ONE;
                redirect <= 1'b1;
              end
            end
            OP_HALT: state <= ST_HALT;
            default: pc <= pc_inc;
          endcase
        end
      end else if (bus.start) begin
        state <= ST_RUN;
        pc    <= '0;
        depth <= '0;
        fault <= FLT_NONE;
      end
    end
  end

  // Entries at or above depth are never read, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[push_idx] <= pc_inc;
    end
  end

  assign bus.pc       = pc;
  assign bus.pc_valid = (state == ST_RUN);
  assign bus.redirect = redirect;
  assign bus.depth    = depth;
  assign bus.halted   = (state == ST_HALT);
  assign bus.fault    = fault;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  pc_sequencer_if #(.CNTR_WIDTH(8), .STACK_DEPTH(8), .DEPTH_W(4)) bus ();

  pc_sequencer #(.CNTR_WIDTH(8), .STACK_DEPTH(8), .DEPTH_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic v, input logic [2:0] code, input logic [7:0] tgt);
    bus.op_valid = v;
    bus.op_code  = code;
    bus.target   = tgt;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    op(1'b0, 3'd0, 8'h00);
    #12;
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_pc_valid", 32'(bus.pc_valid), 32'h0);
    chk("rst_redirect", 32'(bus.redirect), 32'h0);
    chk("rst_depth", 32'(bus.depth), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    step();
    chk("idle_no_start_valid", 32'(bus.pc_valid), 32'h0);
    rst_n = 1'b1;

    do_start();
    chk("start_pc", 32'(bus.pc), 32'h0);
    chk("start_valid", 32'(bus.pc_valid), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", 32'(bus.pc), 32'(i));
      chk("seq_redirect", 32'(bus.redirect), 32'h0);
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", 32'(bus.pc), 32'h0);
    chk("async_rst_valid", 32'(bus.pc_valid), 32'h0);
    #2;
    rst_n = 1'b1;

    do_start();
    for (int i = 0; i < 4; i++) step();
    chk("pre_call_pc", 32'(bus.pc), 32'h4);
    op(1'b1, 3'd2, 8'h20);
    step();
    chk("call_pc", 32'(bus.pc), 32'h20);
    chk("call_redirect", 32'(bus.redirect), 32'h1);
    chk("call_depth", 32'(bus.depth), 32'h1);
    op(1'b0, 3'd2, 8'h00);
    step();
    chk("body_pc1", 32'(bus.pc), 32'h21);
    chk("body_redirect", 32'(bus.redirect), 32'h0);
    step();
    chk("body_pc2", 32'(bus.pc), 32'h22);
    op(1'b1, 3'd3, 8'h00);
    step();
    chk("ret_pc", 32'(bus.pc), 32'h5);
    chk("ret_redirect", 32'(bus.redirect), 32'h1);
    chk("ret_depth", 32'(bus.depth), 32'h0);

    for (int i = 0; i < 8; i++) begin
      op(1'b1, 3'd2, 8'(8'h80 + i));
      step();
      chk("nest_pc", 32'(bus.pc), 32'(8'h80 + i));
      chk("nest_depth", 32'(bus.depth), 32'(i + 1));
    end
    op(1'b1, 3'd3, 8'h00);
    step();
    chk("lifo_top", 32'(bus.pc), 32'h87);
    chk("lifo_depth", 32'(bus.depth), 32'h7);
    op(1'b1, 3'd2, 8'h90);
    step();
    chk("refill_depth", 32'(bus.depth), 32'h8);
    op(1'b1, 3'd2, 8'h50);
    step();
    chk("ovf_fault", 32'(bus.fault), 32'h1);
    chk("ovf_valid", 32'(bus.pc_valid), 32'h0);
    chk("ovf_pc", 32'(bus.pc), 32'h90);
    chk("ovf_depth", 32'(bus.depth), 32'h8);
    op(1'b1, 3'd1, 8'h33);
    step();
    chk("fault_frozen_pc", 32'(bus.pc), 32'h90);
    chk("fault_sticky", 32'(bus.fault), 32'h1);
    op(1'b0, 3'd0, 8'h00);
    do_start();
    chk("restart_pc", 32'(bus.pc), 32'h0);
    chk("restart_depth", 32'(bus.depth), 32'h0);
    chk("restart_fault", 32'(bus.fault), 32'h0);

    op(1'b1, 3'd3, 8'h00);
    step();
    chk("unf_fault", 32'(bus.fault), 32'h2);
    chk("unf_pc", 32'(bus.pc), 32'h0);
    chk("unf_valid", 32'(bus.pc_valid), 32'h0);
    op(1'b0, 3'd0, 8'h00);
    do_start();

    op(1'b1, 3'd1, 8'hFE);
    step();
    chk("jmp_pc", 32'(bus.pc), 32'hFE);
    chk("jmp_redirect", 32'(bus.redirect), 32'h1);
    op(1'b1, 3'd6, 8'h55);
    step();
    chk("wrap_ff", 32'(bus.pc), 32'hFF);
    op(1'b0, 3'd0, 8'h00);
    step();
    chk("wrap_00", 32'(bus.pc), 32'h00);
    step();
    chk("wrap_01", 32'(bus.pc), 32'h01);

    bus.stall = 1'b1;
    op(1'b1, 3'd1, 8'h40);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(bus.pc), 32'h01);
      chk("stall_redirect", 32'(bus.redirect), 32'h0);
    end
    bus.stall = 1'b0;
    step();
    chk("unstall_pc", 32'(bus.pc), 32'h40);
    chk("unstall_redirect", 32'(bus.redirect), 32'h1);
    bus.stall = 1'b1;
    op(1'b1, 3'd3, 8'h00);
    step();
    chk("stall_beats_fault", 32'(bus.fault), 32'h0);
    chk("stall_beats_valid", 32'(bus.pc_valid), 32'h1);
    bus.stall = 1'b0;

    op(1'b1, 3'd1, 8'h07);
    step();
    chk("pre_halt_pc", 32'(bus.pc), 32'h07);
    op(1'b1, 3'd4, 8'h00);
    step();
    chk("halt_halted", 32'(bus.halted), 32'h1);
    chk("halt_pc", 32'(bus.pc), 32'h07);
    chk("halt_valid", 32'(bus.pc_valid), 32'h0);
    op(1'b1, 3'd1, 8'h10);
    step();
    chk("halt_ignore_pc", 32'(bus.pc), 32'h07);
    chk("halt_ignore_halted", 32'(bus.halted), 32'h1);

    op(1'b0, 3'd0, 8'h00);
    do_start();
    chk("unhalt_halted", 32'(bus.halted), 32'h0);
    op(1'b1, 3'd1, 8'hFF);
    step();
    op(1'b1, 3'd2, 8'h30);
    step();
    chk("call_wrap_pc", 32'(bus.pc), 32'h30);
    op(1'b1, 3'd3, 8'h00);
    step();
    chk("call_wrap_ret", 32'(bus.pc), 32'h00);
    chk("call_wrap_depth", 32'(bus.depth), 32'h0);
    op(1'b0, 3'd0, 8'h00);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
